// File: rtl/alu_seq_pkg.sv
// Shared definitions for the ALU control sequencer: opcodes, states, IR field
// positions and the opcode-class decode.
package alu_seq_pkg;

   localparam logic [4:0] OP_ADD  = 5'd3;
   localparam logic [4:0] OP_SUB  = 5'd4;
   localparam logic [4:0] OP_AND  = 5'd5;
   localparam logic [4:0] OP_OR   = 5'd6;
   localparam logic [4:0] OP_SHR  = 5'd7;
   localparam logic [4:0] OP_SHRA = 5'd8;
   localparam logic [4:0] OP_SHL  = 5'd9;
   localparam logic [4:0] OP_ROR  = 5'd10;
   localparam logic [4:0] OP_ROL  = 5'd11;
   localparam logic [4:0] OP_MUL  = 5'd15;
   localparam logic [4:0] OP_DIV  = 5'd16;
   localparam logic [4:0] OP_NEG  = 5'd17;
   localparam logic [4:0] OP_NOT  = 5'd18;

   localparam int OP_MSB = 31;
   localparam int OP_LSB = 27;
   localparam int RA_MSB = 26;
   localparam int RA_LSB = 23;
   localparam int RB_MSB = 22;
   localparam int RB_LSB = 19;
   localparam int RC_MSB = 18;
   localparam int RC_LSB = 15;

   typedef enum logic [3:0] {
      S_IDLE, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_FAULT
   } state_t;

   typedef enum logic [1:0] {
      CLS_ILLEGAL, CLS_BINARY, CLS_UNARY, CLS_LONG
   } op_class_t;

   function automatic op_class_t op_class(input logic [4:0] op);
      case (op)
         OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR, OP_SHRA,
         OP_SHL, OP_ROR, OP_ROL:         return CLS_BINARY;
         OP_MUL, OP_DIV:                 return CLS_LONG;
         OP_NEG, OP_NOT:                 return CLS_UNARY;
         default:                        return CLS_ILLEGAL;
      endcase
   endfunction

endpackage

// File: rtl/alu_sequencer_if.sv
// Handshake and datapath strobe bundle between the sequencer (slave) and the
// environment that feeds it instructions and consumes its strobes (master).
interface alu_sequencer_if #(parameter int NUM_REGS = 16);
   logic                start;
   logic                run_cont;
   logic [31:0]         mem_data;
   logic                mem_ready;
   logic                PCout, IncPC, MARin, memRead, MDRin, MDRout, IRin;
   logic                Yin, Zin, Zlowout, Zhighout, LOin, HIin;
   logic [NUM_REGS-1:0] R_in;
   logic [NUM_REGS-1:0] R_out;
   logic [4:0]          alu_op;
   logic                done;
   logic                fault;
   logic                busy;

   modport master (
      output start, run_cont, mem_data, mem_ready,
      input  PCout, IncPC, MARin, memRead, MDRin, MDRout, IRin,
             Yin, Zin, Zlowout, Zhighout, LOin, HIin,
             R_in, R_out, alu_op, done, fault, busy
   );

   modport slave (
      input  start, run_cont, mem_data, mem_ready,
      output PCout, IncPC, MARin, memRead, MDRin, MDRout, IRin,
             Yin, Zin, Zlowout, Zhighout, LOin, HIin,
             R_in, R_out, alu_op, done, fault, busy
   );
endinterface

// File: rtl/onehot_dec.sv
// Index-to-one-hot decoder with enable; out-of-range indices decode to zero.
module onehot_dec #(
   parameter int N = 16,
   parameter int W = $clog2(N)
) (
   input  logic         en_i,
   input  logic [W-1:0] sel_i,
   output logic [N-1:0] dec_o
);

   always_comb begin
      dec_o = '0;
      if (en_i) dec_o = N'(1) << sel_i;
   end

endmodule

// File: rtl/alu_sequencer.sv
// Hardwired fetch/execute control sequencer for register-to-register ALU
// instructions; all strobes are Moore except MDRin, which follows mem_ready in T1.
//
// state | meaning
// IDLE  | waiting for start, all outputs low
// T0    | PC to MAR, increment PC
// T1    | memory read, wait for mem_ready, latch instruction on exit
// T2    | MDR to IR, decode and legality check
// T3-T6 | execute steps, count depends on opcode class
// FAULT | illegal instruction, sticky until clear
module alu_sequencer
   import alu_seq_pkg::*;
#(
   parameter int NUM_REGS  = 16,
   parameter int REG_SEL_W = $clog2(NUM_REGS)
) (
   input  logic          clock,
   input  logic          clear,
   alu_sequencer_if.slave bus
);

   state_t      state_q, state_d;
   logic [31:0] ir_q, ir_d;

   logic [4:0]  op;
   logic [3:0]  ra, rb, rc;
   op_class_t   cls;
   logic        regs_bad;
   logic        final_step;
   logic        rin_en, rout_en;
   logic [3:0]  rin_field, rout_field;
   logic        unused_ir_bits;

   assign op  = ir_q[OP_MSB:OP_LSB];
   assign ra  = ir_q[RA_MSB:RA_LSB];
   assign rb  = ir_q[RB_MSB:RB_LSB];
   assign rc  = ir_q[RC_MSB:RC_LSB];
   assign cls = op_class(op);
   assign unused_ir_bits = ^ir_q[RC_LSB-1:0];

   function automatic logic oob(input logic [3:0] f);
      return 32'(f) >= 32'(NUM_REGS);
   endfunction

   // Only fields the instruction class actually uses are range-checked.
   always_comb begin
      regs_bad = 1'b0;
      case (cls)
         CLS_BINARY: regs_bad = oob(ra) || oob(rb) || oob(rc);
         CLS_UNARY,
         CLS_LONG:   regs_bad = oob(ra) || oob(rb);
         default:    regs_bad = 1'b0;
      endcase
   end

   always_ff @(posedge clock or posedge clear) begin
      if (clear) begin
         state_q <= S_IDLE;
         ir_q    <= '0;
      end else begin
         state_q <= state_d;
         ir_q    <= ir_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      ir_d         = ir_q;
      final_step   = 1'b0;
      rin_en       = 1'b0;
      rout_en      = 1'b0;
      rin_field    = '0;
      rout_field   = '0;
      bus.PCout    = 1'b0;
      bus.IncPC    = 1'b0;
      bus.MARin    = 1'b0;
      bus.memRead  = 1'b0;
      bus.MDRin    = 1'b0;
      bus.MDRout   = 1'b0;
      bus.IRin     = 1'b0;
      bus.Yin      = 1'b0;
      bus.Zin      = 1'b0;
      bus.Zlowout  = 1'b0;
      bus.Zhighout = 1'b0;
      bus.LOin     = 1'b0;
      bus.HIin     = 1'b0;
      bus.alu_op   = '0;
      bus.done     = 1'b0;

      case (state_q)
         S_IDLE: if (bus.start) state_d = S_T0;
         S_T0: begin
            bus.PCout = 1'b1;
            bus.IncPC = 1'b1;
            bus.MARin = 1'b1;
            state_d   = S_T1;
         end
         S_T1: begin
            bus.memRead = 1'b1;
            bus.MDRin   = bus.mem_ready;
            if (bus.mem_ready) begin
               ir_d    = bus.mem_data;
               state_d = S_T2;
            end
         end
         S_T2: begin
            bus.MDRout = 1'b1;
            bus.IRin   = 1'b1;
            state_d    = (cls == CLS_ILLEGAL || regs_bad) ? S_FAULT : S_T3;
         end
         S_T3: begin
            rout_en = 1'b1;
            state_d = S_T4;
            if (cls == CLS_LONG) begin
               rout_field = ra;
               bus.Yin    = 1'b1;
            end else if (cls == CLS_UNARY) begin
               rout_field = rb;
               bus.Zin    = 1'b1;
               bus.alu_op = op;
            end else begin
               rout_field = rb;
               bus.Yin    = 1'b1;
            end
         end
         S_T4: begin
            state_d = S_T5;
            if (cls == CLS_UNARY) begin
               bus.Zlowout = 1'b1;
               rin_en      = 1'b1;
               rin_field   = ra;
               bus.done    = 1'b1;
               final_step  = 1'b1;
            end else begin
               rout_en    = 1'b1;
               rout_field = (cls == CLS_LONG) ? rb : rc;
               bus.Zin    = 1'b1;
               bus.alu_op = op;
            end
         end
         S_T5: begin
            bus.Zlowout = 1'b1;
            if (cls == CLS_LONG) begin
               bus.LOin = 1'b1;
               state_d  = S_T6;
            end else begin
               rin_en     = 1'b1;
               rin_field  = ra;
               bus.done   = 1'b1;
               final_step = 1'b1;
            end
         end
         S_T6: begin
            bus.Zhighout = 1'b1;
            bus.HIin     = 1'b1;
            bus.done     = 1'b1;
            final_step   = 1'b1;
         end
         S_FAULT: state_d = S_FAULT;
         default: state_d = S_IDLE;
      endcase

      if (final_step) state_d = bus.run_cont ? S_T0 : S_IDLE;
   end

   assign bus.fault = (state_q == S_FAULT);
   assign bus.busy  = (state_q != S_IDLE) && (state_q != S_FAULT);

   onehot_dec #(.N(NUM_REGS), .W(REG_SEL_W)) u_rin_dec (
      .en_i  (rin_en),
      .sel_i (rin_field[REG_SEL_W-1:0]),
      .dec_o (bus.R_in)
   );

   onehot_dec #(.N(NUM_REGS), .W(REG_SEL_W)) u_rout_dec (
      .en_i  (rout_en),
      .sel_i (rout_field[REG_SEL_W-1:0]),
      .dec_o (bus.R_out)
   );

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer: 16-register instance for the main flows,
// 8-register instance for the register-range fault and decoder width.
module tb_alu_sequencer;

   localparam logic [15:0] M_PCOUT  = 16'h8000;
   localparam logic [15:0] M_INCPC  = 16'h4000;
   localparam logic [15:0] M_MARIN  = 16'h2000;
   localparam logic [15:0] M_MEMRD  = 16'h1000;
   localparam logic [15:0] M_MDRIN  = 16'h0800;
   localparam logic [15:0] M_MDROUT = 16'h0400;
   localparam logic [15:0] M_IRIN   = 16'h0200;
   localparam logic [15:0] M_YIN    = 16'h0100;
   localparam logic [15:0] M_ZIN    = 16'h0080;
   localparam logic [15:0] M_ZLO    = 16'h0040;
   localparam logic [15:0] M_ZHI    = 16'h0020;
   localparam logic [15:0] M_LOIN   = 16'h0010;
   localparam logic [15:0] M_HIIN   = 16'h0008;
   localparam logic [15:0] M_DONE   = 16'h0004;
   localparam logic [15:0] M_FAULT  = 16'h0002;
   localparam logic [15:0] M_BUSY   = 16'h0001;
   localparam logic [15:0] M_T0     = M_PCOUT | M_INCPC | M_MARIN | M_BUSY;
   localparam logic [15:0] M_T1     = M_MEMRD | M_MDRIN | M_BUSY;
   localparam logic [15:0] M_T2     = M_MDROUT | M_IRIN | M_BUSY;

   logic clock = 1'b0;
   logic clear = 1'b1;
   int   checks = 0;
   int   passed = 0;

   alu_sequencer_if #(.NUM_REGS(16)) if16 ();
   alu_sequencer_if #(.NUM_REGS(8))  if8 ();

   alu_sequencer #(.NUM_REGS(16)) dut16 (.clock(clock), .clear(clear), .bus(if16));
   alu_sequencer #(.NUM_REGS(8))  dut8  (.clock(clock), .clear(clear), .bus(if8));

   always #5 clock = ~clock;

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   function automatic logic [15:0] strobes16();
      return {if16.PCout, if16.IncPC, if16.MARin, if16.memRead, if16.MDRin,
              if16.MDRout, if16.IRin, if16.Yin, if16.Zin, if16.Zlowout,
              if16.Zhighout, if16.LOin, if16.HIin, if16.done, if16.fault, if16.busy};
   endfunction

   function automatic logic [15:0] strobes8();
      return {if8.PCout, if8.IncPC, if8.MARin, if8.memRead, if8.MDRin,
              if8.MDRout, if8.IRin, if8.Yin, if8.Zin, if8.Zlowout,
              if8.Zhighout, if8.LOin, if8.HIin, if8.done, if8.fault, if8.busy};
   endfunction

   function automatic logic [52:0] obs16();
      return {strobes16(), if16.R_in, if16.R_out, if16.alu_op};
   endfunction

   function automatic logic [36:0] obs8();
      return {strobes8(), if8.R_in, if8.R_out, if8.alu_op};
   endfunction

   function automatic logic [52:0] mk16(input logic [15:0] m, input logic [15:0] rin,
                                        input logic [15:0] rout, input logic [4:0] op);
      return {m, rin, rout, op};
   endfunction

   function automatic logic [36:0] mk8(input logic [15:0] m, input logic [7:0] rin,
                                       input logic [7:0] rout, input logic [4:0] op);
      return {m, rin, rout, op};
   endfunction

   task automatic test_reset();
      step();
      step();
      checks++;
      if (obs16() !== 53'd0) $display("FAIL reset16: got %h want 0", obs16());
      else passed++;
      checks++;
      if (obs8() !== 37'd0) $display("FAIL reset8: got %h want 0", obs8());
      else passed++;
      clear = 1'b0;
   endtask

   // NOT R6,R7; start is also held high mid-instruction and must be ignored.
   task automatic test_unary();
      logic [52:0] exp [6];
      int done_at;
      exp = '{mk16(M_T0, 0, 0, 0), mk16(M_T1, 0, 0, 0), mk16(M_T2, 0, 0, 0),
              mk16(M_ZIN | M_BUSY, 16'h0000, 16'h0080, 5'd18),
              mk16(M_ZLO | M_DONE | M_BUSY, 16'h0040, 16'h0000, 5'd0),
              mk16(16'h0, 0, 0, 0)};
      if16.mem_data = 32'h9338_0000;
      if16.mem_ready = 1'b1;
      if16.run_cont = 1'b0;
      if16.start = 1'b1;
      done_at = 0;
      for (int i = 0; i < 6; i++) begin
         step();
         checks++;
         if (obs16() !== exp[i]) $display("FAIL unary step %0d: got %h want %h", i, obs16(), exp[i]);
         else passed++;
         if (if16.done && done_at == 0) done_at = i + 1;
         if16.start = (i == 1 || i == 2);
      end
      checks++;
      if (done_at !== 5) $display("FAIL unary latency: got %0d want 5", done_at);
      else passed++;
   endtask

   task automatic test_binary();
      logic [52:0] exp [7];
      exp = '{mk16(M_T0, 0, 0, 0), mk16(M_T1, 0, 0, 0), mk16(M_T2, 0, 0, 0),
              mk16(M_YIN | M_BUSY, 16'h0000, 16'h0004, 5'd0),
              mk16(M_ZIN | M_BUSY, 16'h0000, 16'h0008, 5'd3),
              mk16(M_ZLO | M_DONE | M_BUSY, 16'h0002, 16'h0000, 5'd0),
              mk16(16'h0, 0, 0, 0)};
      if16.mem_data = 32'h1891_8000;
      if16.start = 1'b1;
      for (int i = 0; i < 7; i++) begin
         step();
         if16.start = 1'b0;
         checks++;
         if (obs16() !== exp[i]) $display("FAIL binary step %0d: got %h want %h", i, obs16(), exp[i]);
         else passed++;
      end
   endtask

   task automatic test_long();
      logic [52:0] exp [8];
      logic [15:0] rin_seen;
      exp = '{mk16(M_T0, 0, 0, 0), mk16(M_T1, 0, 0, 0), mk16(M_T2, 0, 0, 0),
              mk16(M_YIN | M_BUSY, 16'h0000, 16'h0010, 5'd0),
              mk16(M_ZIN | M_BUSY, 16'h0000, 16'h0020, 5'd15),
              mk16(M_ZLO | M_LOIN | M_BUSY, 0, 0, 0),
              mk16(M_ZHI | M_HIIN | M_DONE | M_BUSY, 0, 0, 0),
              mk16(16'h0, 0, 0, 0)};
      if16.mem_data = 32'h7A28_0000;
      if16.start = 1'b1;
      rin_seen = '0;
      for (int i = 0; i < 8; i++) begin
         step();
         if16.start = 1'b0;
         rin_seen |= if16.R_in;
         checks++;
         if (obs16() !== exp[i]) $display("FAIL long step %0d: got %h want %h", i, obs16(), exp[i]);
         else passed++;
      end
      checks++;
      if (rin_seen !== 16'h0) $display("FAIL long R_in: got %h want 0", rin_seen);
      else passed++;
   endtask

   // mem_ready low for three T1 cycles, then raised mid-cycle for the fourth.
   task automatic test_mem_wait();
      logic [52:0] exp [4];
      int done_at;
      exp = '{mk16(M_T2, 0, 0, 0),
              mk16(M_ZIN | M_BUSY, 16'h0000, 16'h0080, 5'd18),
              mk16(M_ZLO | M_DONE | M_BUSY, 16'h0040, 16'h0000, 5'd0),
              mk16(16'h0, 0, 0, 0)};
      if16.mem_data = 32'h9338_0000;
      if16.mem_ready = 1'b0;
      if16.start = 1'b1;
      done_at = 0;
      step();
      if16.start = 1'b0;
      for (int k = 0; k < 3; k++) begin
         step();
         checks++;
         if (obs16() !== mk16(M_MEMRD | M_BUSY, 0, 0, 0))
            $display("FAIL wait T1 cycle %0d: got %h want %h", k, obs16(), mk16(M_MEMRD | M_BUSY, 0, 0, 0));
         else passed++;
      end
      step();
      if16.mem_ready = 1'b1;
      #1;
      checks++;
      if (obs16() !== mk16(M_T1, 0, 0, 0)) $display("FAIL wait MDRin: got %h want %h", obs16(), mk16(M_T1, 0, 0, 0));
      else passed++;
      for (int i = 0; i < 4; i++) begin
         step();
         checks++;
         if (obs16() !== exp[i]) $display("FAIL wait step %0d: got %h want %h", i, obs16(), exp[i]);
         else passed++;
         if (if16.done && done_at == 0) done_at = i + 6;
      end
      checks++;
      if (done_at !== 8) $display("FAIL wait latency: got %0d want 8", done_at);
      else passed++;
   endtask

   task automatic test_fault_opcode();
      if16.mem_data = 32'h0000_0000;
      if16.mem_ready = 1'b1;
      if16.start = 1'b1;
      step();
      if16.start = 1'b0;
      step();
      step();
      checks++;
      if (obs16() !== mk16(M_T2, 0, 0, 0)) $display("FAIL fault T2: got %h want %h", obs16(), mk16(M_T2, 0, 0, 0));
      else passed++;
      step();
      checks++;
      if (obs16() !== mk16(M_FAULT, 0, 0, 0)) $display("FAIL fault entry: got %h want %h", obs16(), mk16(M_FAULT, 0, 0, 0));
      else passed++;
      if16.start = 1'b1;
      step();
      step();
      checks++;
      if (obs16() !== mk16(M_FAULT, 0, 0, 0)) $display("FAIL fault sticky: got %h want %h", obs16(), mk16(M_FAULT, 0, 0, 0));
      else passed++;
      if16.start = 1'b0;
      clear = 1'b1;
      #1;
      checks++;
      if (obs16() !== 53'd0) $display("FAIL fault clear: got %h want 0", obs16());
      else passed++;
      step();
      clear = 1'b0;
      step();
      checks++;
      if (obs16() !== 53'd0) $display("FAIL fault idle after clear: got %h want 0", obs16());
      else passed++;
   endtask

   task automatic test_fault_reg8();
      if8.mem_data = 32'h9488_0000;
      if8.mem_ready = 1'b1;
      if8.run_cont = 1'b0;
      if8.start = 1'b1;
      step();
      if8.start = 1'b0;
      step();
      step();
      checks++;
      if (obs8() !== mk8(M_T2, 0, 0, 0)) $display("FAIL reg8 T2: got %h want %h", obs8(), mk8(M_T2, 0, 0, 0));
      else passed++;
      step();
      checks++;
      if (obs8() !== mk8(M_FAULT, 0, 0, 0)) $display("FAIL reg8 fault: got %h want %h", obs8(), mk8(M_FAULT, 0, 0, 0));
      else passed++;
      clear = 1'b1;
      step();
      clear = 1'b0;
      // NOT R7,R6 uses the highest legal index on the 8-register instance.
      if8.mem_data = 32'h93B0_0000;
      if8.start = 1'b1;
      step();
      if8.start = 1'b0;
      step();
      step();
      step();
      checks++;
      if (obs8() !== mk8(M_ZIN | M_BUSY, 8'h00, 8'h40, 5'd18))
         $display("FAIL reg8 T3: got %h want %h", obs8(), mk8(M_ZIN | M_BUSY, 8'h00, 8'h40, 5'd18));
      else passed++;
      step();
      checks++;
      if (obs8() !== mk8(M_ZLO | M_DONE | M_BUSY, 8'h80, 8'h00, 5'd0))
         $display("FAIL reg8 T4: got %h want %h", obs8(), mk8(M_ZLO | M_DONE | M_BUSY, 8'h80, 8'h00, 5'd0));
      else passed++;
      step();
      checks++;
      if (obs8() !== 37'd0) $display("FAIL reg8 idle: got %h want 0", obs8());
      else passed++;
   endtask

   task automatic test_back_to_back();
      logic [52:0] exp [10];
      for (int i = 0; i < 10; i++) begin
         case (i % 5)
            0:       exp[i] = mk16(M_T0, 0, 0, 0);
            1:       exp[i] = mk16(M_T1, 0, 0, 0);
            2:       exp[i] = mk16(M_T2, 0, 0, 0);
            3:       exp[i] = mk16(M_ZIN | M_BUSY, 16'h0000, 16'h0080, 5'd18);
            default: exp[i] = mk16(M_ZLO | M_DONE | M_BUSY, 16'h0040, 16'h0000, 5'd0);
         endcase
      end
      if16.mem_data = 32'h9338_0000;
      if16.mem_ready = 1'b1;
      if16.run_cont = 1'b1;
      if16.start = 1'b1;
      for (int i = 0; i < 10; i++) begin
         step();
         if16.start = 1'b0;
         checks++;
         if (obs16() !== exp[i]) $display("FAIL cont step %0d: got %h want %h", i, obs16(), exp[i]);
         else passed++;
      end
      clear = 1'b1;
      #1;
      checks++;
      if (obs16() !== 53'd0) $display("FAIL cont abort: got %h want 0", obs16());
      else passed++;
      step();
      clear = 1'b0;
      if16.run_cont = 1'b0;
      step();
      checks++;
      if (obs16() !== 53'd0) $display("FAIL cont idle: got %h want 0", obs16());
      else passed++;
   endtask

   task automatic test_start_clear();
      clear = 1'b1;
      if16.start = 1'b1;
      step();
      checks++;
      if (obs16() !== 53'd0) $display("FAIL start+clear: got %h want 0", obs16());
      else passed++;
      clear = 1'b0;
      step();
      if16.start = 1'b0;
      checks++;
      if (obs16() !== mk16(M_T0, 0, 0, 0)) $display("FAIL start after clear: got %h want %h", obs16(), mk16(M_T0, 0, 0, 0));
      else passed++;
      clear = 1'b1;
      step();
      clear = 1'b0;
   endtask

   initial begin
      if16.start = 1'b0;
      if16.run_cont = 1'b0;
      if16.mem_data = '0;
      if16.mem_ready = 1'b0;
      if8.start = 1'b0;
      if8.run_cont = 1'b0;
      if8.mem_data = '0;
      if8.mem_ready = 1'b0;
      test_reset();
      test_unary();
      test_binary();
      test_long();
      test_mem_wait();
      test_fault_opcode();
      test_fault_reg8();
      test_back_to_back();
      test_start_clear();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule

// File: doc/alu_sequencer.md
# alu_sequencer

Hardwired control sequencer that drives the datapath's control lines for register-to-register ALU instructions. It runs fetch (T0–T2) and the execute steps (T3–T6) automatically, with a memory-ready handshake, parametrised register count, and single-step or continuous run modes. It sits beside the CPU datapath; its outputs connect one-to-one to the datapath's enable/strobe inputs, and it replaces per-step testbench stimulus.

## Interface
- NUM_REGS, 16: general registers; R_in/R_out width; 2..16
- REG_SEL_W, $clog2(NUM_REGS): internal index width
- clock  in  1  sole clock, rising edge
- clear  in  1  asynchronous, active-high reset
- start  in  1  begin one instruction (sampled in IDLE)
- run_cont  in  1  1: after final step go straight to T0; sampled at final step
- mem_data  in  32  memory read data (instruction word)
- mem_ready  in  1  memory data valid this cycle
- PCout, IncPC, MARin, memRead, MDRin, MDRout, IRin, Yin, Zin, Zlowout, Zhighout, LOin, HIin  out  1 each  datapath strobes
- R_in, R_out  out  NUM_REGS  one-hot register write/read enables
- alu_op  out  5  opcode presented to ALU (valid while Zin=1, else 0)
- done  out  1  one-cycle pulse in final execute step
- fault  out  1  sticky illegal-instruction flag
- busy  out  1  state != IDLE and != FAULT

## Operation
- IR fields: op=[31:27], Ra=[26:23], Rb=[22:19], Rc=[18:15]; instruction word latched internally from mem_data on the T1 exit edge.
- Opcodes: binary add 3, sub 4, and 5, or 6, shr 7, shra 8, shl 9, ror 10, rol 11; long mul 15, div 16; unary neg 17, not 18. Any other opcode is illegal.
- States: IDLE, T0, T1, T2, T3, T4, T5, T6, FAULT.
- IDLE: all outputs 0; start=1 -> T0.
- T0: PCout, IncPC, MARin -> T1.
- T1: memRead=1 every cycle; MDRin=mem_ready (Mealy); stay until mem_ready=1, then -> T2.
- T2: MDRout, IRin; decode: illegal op, or any used register field >= NUM_REGS -> FAULT, else -> T3.
- Binary: T3 R_out[Rb], Yin; T4 R_out[Rc], Zin, alu_op=op; T5 Zlowout, R_in[Ra], done.
- Unary: T3 R_out[Rb], Zin, alu_op=op; T4 Zlowout, R_in[Ra], done.
- Long: T3 R_out[Ra], Yin; T4 R_out[Rb], Zin, alu_op=op; T5 Zlowout, LOin; T6 Zhighout, HIin, done.
- After final step: run_cont=1 -> T0, else -> IDLE.
- FAULT: fault=1, all strobes 0, start ignored; exit only via clear.
- At most one R_out bit and at most one bus driver (PCout/MDRout/Zlowout/Zhighout/R_out) active per cycle.

## Timing
- clear=1: state IDLE, every output 0 (including fault, done, busy), latched IR 0, applied asynchronously; clear mid-instruction aborts with no further strobe.
- Strobes are Moore, decoded from registered state and latched fields, except MDRin in T1; each strobe high exactly one cycle per step.
- Latency start -> done with mem_ready already high: unary 5 cycles, binary 6, long 7; each extra T1 wait cycle adds 1.
- start during busy ignored; start and clear together: clear wins.
- Continuous mode: no idle cycle between done and next T0.

## Structure
- Package alu_seq_pkg: opcode constants, state enum, IR field bit positions, op-class function (binary/unary/long/illegal).
- Sub-module onehot_dec (REG_SEL_W -> NUM_REGS decoder with enable), instantiated twice for R_in and R_out.

## Test plan
- NOT R6,R7, mem_data=0x93380000, mem_ready=1 -> T3 R_out=0x0080, Zin, alu_op=18; T4 Zlowout, R_in=0x0040, done; 5 cycles start->done; back to IDLE.
- ADD R1,R2,R3, 0x18918000 -> T3 R_out=0x0004+Yin; T4 R_out=0x0008+Zin, alu_op=3; T5 R_in=0x0002+Zlowout+done.
- MUL R4,R5, 0x7A280000 -> T5 Zlowout+LOin, T6 Zhighout+HIin+done; R_in never asserted.
- mem_ready low 3 cycles in T1 -> memRead=1, MDRin=0 for 3 cycles, MDRin=1 on 4th, then T2.
- mem_data=0x00000000, or NUM_REGS=8 with Ra=9 -> FAULT after T2, fault=1, no R_in/HIin/LOin, start ignored until clear.
- run_cont=1 with two NOTs -> second T0 immediately after first done; clear asserted during T4 -> outputs 0 same cycle, IDLE.
